// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture buffer: FSM state encoding and
// capture channel select codes.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READ    = 2'd3
    } cap_state_e;

    typedef enum logic [1:0] {
        CHAN_A = 2'd0,
        CHAN_C = 2'd1,
        CHAN_E = 2'd2,
        CHAN_G = 2'd3
    } chan_sel_e;

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port,
// written so that synthesis maps it onto block RAM.
module adc_capture_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; output holds between reads
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/adc_capture_buf.sv
// Triggered single-shot capture of one deserialized ADC channel into RAM,
// followed by an in-order valid/ready readout of the captured samples.
module adc_capture_buf
    import adc_capture_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              fco_clk,
    input  logic              fco_rst_n,
    input  logic              fco_clk_rdy,
    input  logic [DATA_W-1:0] iser_chan_a,
    input  logic [DATA_W-1:0] iser_chan_c,
    input  logic [DATA_W-1:0] iser_chan_e,
    input  logic [DATA_W-1:0] iser_chan_g,
    input  logic [1:0]        sel_chan,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [ADDR_W:0]   capture_len,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    cap_state_e        state_r;
    chan_sel_e         sel_r;
    logic              mode_r;
    logic [DATA_W-1:0] level_r;
    logic [CNT_W-1:0]  len_r;
    logic [CNT_W-1:0]  wr_cnt_r;
    logic [CNT_W-1:0]  rd_addr_r;
    logic              hist_valid_r;
    logic              hist_below_r;
    logic              busy_r;
    logic              done_r;
    logic              pend_r;
    logic              pend_last_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic [DATA_W-1:0] out_data_r;
    logic              skid_valid_r;
    logic              skid_last_r;
    logic [DATA_W-1:0] skid_data_r;

    logic [CNT_W-1:0]  eff_len_s;
    logic [DATA_W-1:0] sample_s;
    logic              below_s;
    logic              trig_s;
    logic              cap_wr_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic              last_wr_s;
    logic              xfer_s;
    logic [1:0]        occ_s;
    logic [1:0]        avail_s;
    logic              issue_s;
    logic [DATA_W-1:0] ram_q_s;

    // Out-of-range lengths capture the whole buffer
    always_comb begin
        eff_len_s = capture_len;
        if ((capture_len == ZERO_C) || (capture_len > DEPTH_C)) begin
            eff_len_s = DEPTH_C;
        end else begin
            eff_len_s = capture_len;
        end
    end

    // Source channel mux
    always_comb begin
        sample_s = iser_chan_a;
        case (sel_r)
            CHAN_A:  sample_s = iser_chan_a;
            CHAN_C:  sample_s = iser_chan_c;
            CHAN_E:  sample_s = iser_chan_e;
            CHAN_G:  sample_s = iser_chan_g;
            default: sample_s = iser_chan_a;
        endcase
    end

    assign below_s = $signed(sample_s) < $signed(level_r);

    // Trigger: a rising crossing needs a valid, below-level predecessor
    always_comb begin
        trig_s = 1'b0;
        if ((state_r == ST_ARMED) && fco_clk_rdy) begin
            if (!mode_r) begin
                trig_s = 1'b1;
            end else begin
                trig_s = hist_valid_r && hist_below_r && !below_s;
            end
        end else begin
            trig_s = 1'b0;
        end
    end

    assign cap_wr_s  = (state_r == ST_CAPTURE) && fco_clk_rdy;
    assign wr_en_s   = trig_s || cap_wr_s;
    assign wr_addr_s = trig_s ? {ADDR_W{1'b0}} : wr_cnt_r[ADDR_W-1:0];
    assign last_wr_s = (trig_s && (len_r == ONE_C)) ||
                       (cap_wr_s && (wr_cnt_r == (len_r - ONE_C)));

    // Readout keeps at most two samples (output + skid) in flight, counting
    // the read issued last cycle, so stalls never lose RAM data.
    assign xfer_s  = out_valid_r && rd_ready;
    assign occ_s   = {1'b0, out_valid_r} + {1'b0, skid_valid_r} + {1'b0, pend_r};
    assign avail_s = occ_s - {1'b0, xfer_s};
    assign issue_s = (state_r == ST_READ) && (rd_addr_r != len_r) && (avail_s < 2'd2);

    adc_capture_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (fco_clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (sample_s),
        .rd_en   (issue_s),
        .rd_addr (rd_addr_r[ADDR_W-1:0]),
        .rd_data (ram_q_s)
    );

    // Capture/readout FSM with registered status and readout outputs
    always_ff @(posedge fco_clk) begin
        if (!fco_rst_n) begin
            state_r      <= ST_IDLE;
            sel_r        <= CHAN_A;
            mode_r       <= 1'b0;
            level_r      <= {DATA_W{1'b0}};
            len_r        <= ZERO_C;
            wr_cnt_r     <= ZERO_C;
            rd_addr_r    <= ZERO_C;
            hist_valid_r <= 1'b0;
            hist_below_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pend_r       <= 1'b0;
            pend_last_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_data_r   <= {DATA_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
            skid_data_r  <= {DATA_W{1'b0}};
        end else if (abort) begin
            state_r      <= ST_IDLE;
            wr_cnt_r     <= ZERO_C;
            rd_addr_r    <= ZERO_C;
            hist_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pend_r       <= 1'b0;
            pend_last_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_data_r   <= {DATA_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm) begin
                        state_r      <= ST_ARMED;
                        sel_r        <= chan_sel_e'(sel_chan);
                        mode_r       <= trig_mode;
                        level_r      <= trig_level;
                        len_r        <= eff_len_s;
                        wr_cnt_r     <= ZERO_C;
                        hist_valid_r <= 1'b0;
                        busy_r       <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    hist_valid_r <= fco_clk_rdy;
                    if (fco_clk_rdy) begin
                        hist_below_r <= below_s;
                    end
                    if (trig_s) begin
                        wr_cnt_r <= ONE_C;
                        if (last_wr_s) begin
                            state_r   <= ST_READ;
                            rd_addr_r <= ZERO_C;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                        end else begin
                            state_r <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (cap_wr_s) begin
                        wr_cnt_r <= wr_cnt_r + ONE_C;
                        if (last_wr_s) begin
                            state_r   <= ST_READ;
                            rd_addr_r <= ZERO_C;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (issue_s) begin
                        rd_addr_r <= rd_addr_r + ONE_C;
                    end
                    pend_r      <= issue_s;
                    pend_last_r <= issue_s && (rd_addr_r == (len_r - ONE_C));
                    if (xfer_s && out_last_r) begin
                        state_r      <= ST_IDLE;
                        done_r       <= 1'b0;
                        out_valid_r  <= 1'b0;
                        out_last_r   <= 1'b0;
                        skid_valid_r <= 1'b0;
                        skid_last_r  <= 1'b0;
                        pend_r       <= 1'b0;
                    end else if (xfer_s || !out_valid_r) begin
                        if (skid_valid_r) begin
                            out_valid_r  <= 1'b1;
                            out_data_r   <= skid_data_r;
                            out_last_r   <= skid_last_r;
                            skid_valid_r <= pend_r;
                            skid_data_r  <= ram_q_s;
                            skid_last_r  <= pend_last_r;
                        end else begin
                            out_valid_r <= pend_r;
                            out_last_r  <= pend_last_r;
                            if (pend_r) begin
                                out_data_r <= ram_q_s;
                            end
                        end
                    end else if (pend_r) begin
                        skid_valid_r <= 1'b1;
                        skid_data_r  <= ram_q_s;
                        skid_last_r  <= pend_last_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign rd_valid = out_valid_r;
    assign rd_data  = out_data_r;
    assign rd_last  = out_last_r;

endmodule

// File: tb/tb_adc_capture_buf.sv
// Directed bench for adc_capture_buf: trigger modes, framing gaps, full-depth
// readout with backpressure, abort and reset behaviour.
module tb_adc_capture_buf;

    logic        fco_clk = 1'b0;
    logic        fco_rst_n;
    logic        fco_clk_rdy;
    logic [15:0] iser_chan_a, iser_chan_c, iser_chan_e, iser_chan_g;
    logic [1:0]  sel_chan;
    logic        arm, abort, trig_mode;
    logic [15:0] trig_level;
    logic [10:0] capture_len;
    logic        busy, done, rd_valid, rd_last, rd_ready;
    logic [15:0] rd_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    adc_capture_buf #(.ADDR_W(10), .DATA_W(16)) dut (
        .fco_clk     (fco_clk),
        .fco_rst_n   (fco_rst_n),
        .fco_clk_rdy (fco_clk_rdy),
        .iser_chan_a (iser_chan_a),
        .iser_chan_c (iser_chan_c),
        .iser_chan_e (iser_chan_e),
        .iser_chan_g (iser_chan_g),
        .sel_chan    (sel_chan),
        .arm         (arm),
        .abort       (abort),
        .trig_mode   (trig_mode),
        .trig_level  (trig_level),
        .capture_len (capture_len),
        .busy        (busy),
        .done        (done),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .rd_ready    (rd_ready)
    );

    always #5 fco_clk = ~fco_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one cycle of channel data; values are sampled at the next posedge
    task automatic feed(input logic [15:0] a, input logic [15:0] c, input logic [15:0] e,
                        input logic [15:0] g, input logic rdy);
        iser_chan_a = a;
        iser_chan_c = c;
        iser_chan_e = e;
        iser_chan_g = g;
        fco_clk_rdy = rdy;
        @(negedge fco_clk);
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    task automatic idle_cycle();
        feed(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    endtask

    // Arm, then scramble the config inputs to prove they were latched
    task automatic do_arm(input logic [1:0] sel, input logic mode, input logic [15:0] lvl,
                          input logic [10:0] len);
        sel_chan    = sel;
        trig_mode   = mode;
        trig_level  = lvl;
        capture_len = len;
        arm         = 1'b1;
        feed(16'hEEEE, 16'hEEEE, 16'hEEEE, 16'hEEEE, 1'b1);
        check("armed_busy", 32'(busy), 32'd1);
        sel_chan    = sel ^ 2'b01;
        trig_mode   = ~mode;
        trig_level  = 16'h7000;
        capture_len = 11'd5;
        exp_q.delete();
    endtask

    task automatic read_samples(input int n_take, input int n_total, input bit rand_rdy);
        int  idx     = 0;
        int  guard   = 0;
        bit  stalled = 1'b0;
        while (idx < n_take && guard < 8000) begin
            rd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) check("rd_valid_hold", 32'(rd_valid), 32'd1);
            if (rd_valid) begin
                check("rd_data", 32'(rd_data), 32'(exp_q[idx]));
                check("rd_last", 32'(rd_last), 32'(idx == n_total - 1));
            end
            stalled = rd_valid && !rd_ready;
            if (rd_valid && rd_ready) idx++;
            @(negedge fco_clk);
            guard++;
        end
        rd_ready = 1'b0;
        if (idx < n_take) check("rd_timeout", 32'(idx), 32'(n_take));
        if (n_take == n_total) begin
            check("end_busy", 32'(busy), 32'd0);
            check("end_done", 32'(done), 32'd0);
            check("end_valid", 32'(rd_valid), 32'd0);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_last"}, 32'(rd_last), 32'd0);
    endtask

    initial begin
        fco_rst_n   = 1'b0;
        fco_clk_rdy = 1'b0;
        iser_chan_a = 16'h0;
        iser_chan_c = 16'h0;
        iser_chan_e = 16'h0;
        iser_chan_g = 16'h0;
        sel_chan    = 2'd0;
        arm         = 1'b0;
        abort       = 1'b0;
        trig_mode   = 1'b0;
        trig_level  = 16'h0;
        capture_len = 11'd0;
        rd_ready    = 1'b0;
        @(negedge fco_clk);
        @(negedge fco_clk);
        check_quiet("reset");
        check("reset_data", 32'(rd_data), 32'd0);
        fco_rst_n = 1'b1;
        idle_cycle();

        // Immediate trigger on channel e, ramp from 100
        do_arm(2'd2, 1'b0, 16'h0000, 11'd8);
        for (int k = 0; k < 8; k++) begin
            feed(16'h1000 + 16'(k), 16'h2000 + 16'(k), 16'd100 + 16'(k), 16'h3000 + 16'(k), 1'b1);
            exp_q.push_back(16'd100 + 16'(k));
        end
        check("imm_done", 32'(done), 32'd1);
        check("imm_busy", 32'(busy), 32'd0);
        read_samples(8, 8, 1'b0);

        // Rising crossing of 0 on channel a; the first sample after arm never triggers
        do_arm(2'd0, 1'b1, 16'h0000, 11'd4);
        feed(16'd3, 16'h0, 16'h0, 16'h0, 1'b1);
        feed(16'hFFFB, 16'h0, 16'h0, 16'h0, 1'b1);
        feed(16'hFFFF, 16'h0, 16'h0, 16'h0, 1'b1);
        check("thr_waiting", 32'(done), 32'd0);
        for (int k = 0; k < 4; k++) begin
            feed(16'd3 + 16'(4 * k), 16'h0, 16'h0, 16'h0, 1'b1);
            exp_q.push_back(16'd3 + 16'(4 * k));
        end
        check("thr_done", 32'(done), 32'd1);
        read_samples(4, 4, 1'b0);

        // Framing gap clears the crossing history
        do_arm(2'd0, 1'b1, 16'h0000, 11'd2);
        feed(16'hFFFC, 16'h0, 16'h0, 16'h0, 1'b1);
        feed(16'd5, 16'h0, 16'h0, 16'h0, 1'b0);
        feed(16'd5, 16'h0, 16'h0, 16'h0, 1'b1);
        feed(16'hFFFE, 16'h0, 16'h0, 16'h0, 1'b1);
        feed(16'd6, 16'h0, 16'h0, 16'h0, 1'b1);
        feed(16'd8, 16'h0, 16'h0, 16'h0, 1'b1);
        exp_q.push_back(16'd6);
        exp_q.push_back(16'd8);
        read_samples(2, 2, 1'b0);

        // Three-cycle framing dropout mid-capture on channel g
        do_arm(2'd3, 1'b0, 16'h0000, 11'd16);
        for (int k = 0; k < 16; k++) begin
            if (k == 5) begin
                for (int j = 0; j < 3; j++) begin
                    feed(16'h0, 16'h0, 16'h0, 16'hDEA0 + 16'(j), 1'b0);
                end
            end
            feed(16'h1111, 16'h2222, 16'h3333, 16'h3000 + 16'(k), 1'b1);
            exp_q.push_back(16'h3000 + 16'(k));
        end
        read_samples(16, 16, 1'b0);

        // Full depth on channel c, random backpressure
        do_arm(2'd1, 1'b0, 16'h0000, 11'd1024);
        for (int k = 0; k < 1024; k++) begin
            feed(16'hAAAA, 16'(k * 7 + 3), 16'hBBBB, 16'hCCCC, 1'b1);
            exp_q.push_back(16'(k * 7 + 3));
        end
        read_samples(1024, 1024, 1'b1);

        // Abort during capture with a simultaneous arm
        do_arm(2'd0, 1'b0, 16'h0000, 11'd8);
        for (int k = 0; k < 3; k++) feed(16'(k), 16'h0, 16'h0, 16'h0, 1'b1);
        abort = 1'b1;
        arm   = 1'b1;
        feed(16'h9, 16'h0, 16'h0, 16'h0, 1'b1);
        check_quiet("abort_cap");
        idle_cycle();
        check("abort_cap_noarm", 32'(busy), 32'd0);

        // Abort during readout with a simultaneous arm
        do_arm(2'd0, 1'b0, 16'h0000, 11'd4);
        for (int k = 0; k < 4; k++) begin
            feed(16'h0500 + 16'(k), 16'h0, 16'h0, 16'h0, 1'b1);
            exp_q.push_back(16'h0500 + 16'(k));
        end
        idle_cycle();
        idle_cycle();
        check("first_valid", 32'(rd_valid), 32'd1);
        check("first_data", 32'(rd_data), 32'(exp_q[0]));
        abort = 1'b1;
        arm   = 1'b1;
        idle_cycle();
        check_quiet("abort_rd");
        idle_cycle();
        check("abort_rd_noarm", 32'(busy), 32'd0);

        // Length one goes straight to readout
        do_arm(2'd2, 1'b0, 16'h0000, 11'd1);
        feed(16'h0, 16'h0, 16'h4242, 16'h0, 1'b1);
        exp_q.push_back(16'h4242);
        check("len1_done", 32'(done), 32'd1);
        check("len1_busy", 32'(busy), 32'd0);
        read_samples(1, 1, 1'b0);

        // Length zero means full depth; reset during readout
        do_arm(2'd0, 1'b0, 16'h0000, 11'd0);
        for (int k = 0; k < 1023; k++) begin
            feed(16'(k) ^ 16'h5A5A, 16'h0, 16'h0, 16'h0, 1'b1);
            exp_q.push_back(16'(k) ^ 16'h5A5A);
        end
        check("len0_busy", 32'(busy), 32'd1);
        check("len0_notdone", 32'(done), 32'd0);
        feed(16'(1023) ^ 16'h5A5A, 16'h0, 16'h0, 16'h0, 1'b1);
        exp_q.push_back(16'(1023) ^ 16'h5A5A);
        check("len0_done", 32'(done), 32'd1);
        read_samples(10, 1024, 1'b0);
        fco_rst_n = 1'b0;
        idle_cycle();
        check_quiet("rst_rd");
        check("rst_rd_data", 32'(rd_data), 32'd0);
        fco_rst_n = 1'b1;
        idle_cycle();
        idle_cycle();
        check_quiet("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
